// File: rtl/frac_clock_divider.sv
// Multi-channel fractional clock-enable generator: each channel emits a one-cycle
// tick at an average period of INT + FRAC/2^FRAC_W clock cycles.
module frac_clock_divider #(
  parameter int CHANNELS = 4,
  parameter int INT_W    = 16,
  parameter int FRAC_W   = 8
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [CHANNELS*(INT_W+FRAC_W)-1:0] divisor,
  input  logic [CHANNELS-1:0]                enable,
  input  logic [CHANNELS-1:0]                restart,
  output logic [CHANNELS-1:0]                tick
);

  localparam int DIV_W = INT_W + FRAC_W;
  localparam logic [INT_W-1:0] CNT_ONE = INT_W'(1);

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    logic [DIV_W-1:0]  div_in;
    logic [DIV_W-1:0]  div_q;
    logic [INT_W-1:0]  int_q;
    logic [FRAC_W-1:0] frac_q;
    logic [INT_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;
    logic              do_restart;
    logic              tick_q;

    assign div_in     = divisor[g*DIV_W +: DIV_W];
    assign int_q      = div_q[DIV_W-1 -: INT_W];
    assign frac_q     = div_q[FRAC_W-1:0];
    assign sum        = {1'b0, acc} + {1'b0, frac_q};
    assign do_restart = restart[g] || (div_in != div_q);

    // A carry out of the accumulator stretches this interval by one cycle,
    // so the reload is INT when carrying and INT-1 otherwise (never overflows).
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        div_q  <= '0;
        cnt    <= '0;
        acc    <= '0;
        tick_q <= 1'b0;
      end else if (do_restart) begin
        div_q  <= div_in;
        cnt    <= '0;
        acc    <= '0;
        tick_q <= 1'b0;
      end else if (!enable[g]) begin
        tick_q <= 1'b0;
      end else if (int_q == '0) begin
        tick_q <= 1'b1;
      end else if (cnt == '0) begin
        tick_q <= 1'b1;
        acc    <= sum[FRAC_W-1:0];
        cnt    <= sum[FRAC_W] ? int_q : (int_q - CNT_ONE);
      end else begin
        tick_q <= 1'b0;
        cnt    <= cnt - CNT_ONE;
      end
    end

    assign tick[g] = tick_q;
  end

endmodule

// File: tb/tb_frac_clock_divider.sv
// Directed testbench for frac_clock_divider: default 4x16.8 instance plus a
// tiny 1x4.2 instance for the carry-at-maximum-divisor case.
`timescale 1ns/1ps
module tb_frac_clock_divider;
  localparam int CH = 4;
  localparam int DW = 24;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [CH*DW-1:0] divisor;
  logic [CH-1:0]   enable;
  logic [CH-1:0]   restart;
  logic [CH-1:0]   tick;

  logic [5:0]      small_div;
  logic [0:0]      small_en;
  logic [0:0]      small_restart;
  logic [0:0]      small_tick;
  logic [4:0]      all_tick;

  int checks = 0;
  int errors = 0;
  int n;
  int cnt;
  int mism;
  logic [2:0] idle;
  logic seen;

  assign all_tick = {small_tick, tick};

  always #5 clock = ~clock;

  frac_clock_divider dut (
    .clock   (clock),
    .reset_n (reset_n),
    .divisor (divisor),
    .enable  (enable),
    .restart (restart),
    .tick    (tick)
  );

  frac_clock_divider #(.CHANNELS(1), .INT_W(4), .FRAC_W(2)) u_small (
    .clock   (clock),
    .reset_n (reset_n),
    .divisor (small_div),
    .enable  (small_en),
    .restart (small_restart),
    .tick    (small_tick)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int ch, input logic [15:0] int_part, input logic [7:0] frac_part);
    divisor[ch*DW +: DW] = {int_part, frac_part};
  endtask

  // Steps until the selected tick is seen (channel 4 = small instance), bounded.
  task automatic next_tick(input int ch, input int limit, output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (!all_tick[ch] && steps < limit);
  endtask

  initial begin
    reset_n = 1'b0;
    divisor = '0;
    enable = '0;
    restart = '0;
    small_div = '0;
    small_en = '0;
    small_restart = '0;
    repeat (3) step();
    checkOutput("reset_tick", int'(all_tick), 0);

    // integer divide by 3
    applyStimulus(0, 16'd3, 8'h00);
    enable = 4'b0001;
    @(negedge clock);
    reset_n = 1'b1;
    next_tick(0, 10, n);
    checkOutput("int_first", n, 2);
    idle = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checkOutput("int_period", int'(tick[0]), (k % 3 == 0) ? 1 : 0);
      idle |= tick[3:1];
    end
    checkOutput("idle_channels", int'(idle), 0);

    // fractional 2.5
    applyStimulus(0, 16'd2, 8'h80);
    next_tick(0, 10, n);
    checkOutput("frac_first", n, 2);
    for (int k = 0; k < 4; k++) begin
      next_tick(0, 10, n);
      checkOutput("frac_2p5_interval", n, (k % 2 == 0) ? 2 : 3);
    end
    cnt = 0;
    repeat (1280) begin
      step();
      cnt += int'(tick[0]);
    end
    checkOutput("frac_2p5_count", cnt, 512);

    // fractional 1.25
    applyStimulus(0, 16'd1, 8'h40);
    next_tick(0, 10, n);
    checkOutput("frac_1p25_first", n, 2);
    for (int k = 0; k < 8; k++) begin
      next_tick(0, 10, n);
      checkOutput("frac_1p25_interval", n, (k % 4 == 3) ? 2 : 1);
    end

    // bypass, then leave bypass with INT=4
    applyStimulus(0, 16'd0, 8'h55);
    step();
    checkOutput("bypass_restart", int'(tick[0]), 0);
    repeat (6) begin
      step();
      checkOutput("bypass_high", int'(tick[0]), 1);
    end
    applyStimulus(0, 16'd4, 8'h00);
    step();
    checkOutput("bypass_exit_low", int'(tick[0]), 0);
    step();
    checkOutput("bypass_exit_tick", int'(tick[0]), 1);
    repeat (2) begin
      next_tick(0, 10, n);
      checkOutput("bypass_exit_period", n, 4);
    end

    // enable gating with 2 cycles remaining
    applyStimulus(0, 16'd5, 8'h00);
    next_tick(0, 10, n);
    checkOutput("gate_first", n, 2);
    next_tick(0, 10, n);
    checkOutput("gate_period", n, 5);
    repeat (3) step();
    enable[0] = 1'b0;
    seen = 1'b0;
    repeat (7) begin
      step();
      seen |= tick[0];
    end
    checkOutput("gate_quiet", int'(seen), 0);
    enable[0] = 1'b1;
    next_tick(0, 10, n);
    checkOutput("gate_resume", n, 2);

    // lockstep restart of ch0 and ch2 from differing phases
    applyStimulus(0, 16'd3, 8'h33);
    repeat (2) step();
    applyStimulus(2, 16'd3, 8'h33);
    enable = 4'b0101;
    repeat (5) step();
    restart = 4'b0101;
    step();
    restart = 4'b0000;
    checkOutput("lockstep_restart", int'({tick[2], tick[0]}), 0);
    mism = 0;
    cnt = 0;
    repeat (1000) begin
      step();
      if (tick[0] !== tick[2]) mism++;
      cnt += int'(tick[0]);
    end
    checkOutput("lockstep_mismatch", mism, 0);
    checkOutput("lockstep_active", int'(cnt >= 250 && cnt <= 340), 1);

    // maximum divisor, then async reset while ch1 (bypass) is ticking
    applyStimulus(0, 16'hFFFF, 8'hFF);
    enable = 4'b0011;
    next_tick(0, 10, n);
    checkOutput("max_first", n, 2);
    next_tick(0, 70000, n);
    checkOutput("max_interval", n, 65535);
    repeat (100) step();
    checkOutput("bypass_ch1_live", int'(tick[1]), 1);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", int'(tick), 0);
    small_div = {4'hF, 2'h3};
    small_en = 1'b1;
    #2;
    reset_n = 1'b1;
    next_tick(0, 10, n);
    checkOutput("reset_restart_first", n, 2);
    checkOutput("small_first", int'(small_tick), 1);
    for (int k = 0; k < 5; k++) begin
      next_tick(4, 40, n);
      checkOutput("small_max_interval", n, (k % 4 == 0) ? 15 : 16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
